// File: rtl/cmd_sequencer_pkg.sv
// Shared protocol constants, state encoding and dimension type for the
// UART command sequencer.
package cmd_sequencer_pkg;

  localparam logic [7:0] MATRIX_MULT = 8'h01;
  localparam logic [7:0] ACK         = 8'hA5;

  typedef logic [7:0] dim_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR,
    ST_ACK,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_START,
    ST_WAIT,
    ST_RD,
    ST_SEND
  } seq_state_t;

  function automatic logic [15:0] elem_count(input dim_t rows, input dim_t cols);
    return 16'(rows) * 16'(cols);
  endfunction

endpackage

// File: rtl/cmd_sequencer_byte_packer.sv
// Assembles four received bytes, MSB first, into a 32-bit word; done pulses
// for one cycle once the fourth byte has been shifted in.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_vld,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic        done
);

  logic [1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= 2'd0;
      word <= 32'd0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clr) begin
        cnt <= 2'd0;
      end else if (in_vld) begin
        word <= {word[23:0], in_byte};
        cnt  <= cnt + 2'd1;
        done <= (cnt == 2'd3);
      end
    end
  end

endmodule

// File: rtl/cmd_sequencer.sv
// Host command sequencer: parses header/operands from the UART, loads the A/B
// buffers, runs the multiply and streams results back. Optional header
// acknowledge byte is enabled with FUMPY_CMD_ACK_EN.
module cmd_sequencer
  import cmd_sequencer_pkg::*;
#(
  parameter int MAX_DIM = 4,
  parameter int ADDR_W  = $clog2(MAX_DIM*MAX_DIM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              tx_send,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  output logic              buf_we,
  output logic              buf_sel,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [31:0]       buf_wdata,
  output logic              mm_start,
  output dim_t              mm_a_h,
  output dim_t              mm_a_w,
  output dim_t              mm_b_w,
  input  logic              mm_done,
  output logic              res_rd_en,
  output logic [ADDR_W-1:0] res_addr,
  input  logic [31:0]       res_rdata,
  output logic              busy,
  output logic              err
);

  seq_state_t        state, state_nxt;
  logic [1:0]        hdr_cnt;
  dim_t              b_h;
  logic [ADDR_W-1:0] word_idx;
  logic [ADDR_W-1:0] res_idx;
  logic [31:0]       res_word;
  logic [1:0]        byte_cnt;
  logic              snd_load;
  logic              tx_wait;
  logic              pk_done;
  logic [31:0]       pk_word;
  logic              loading, hdr_last, hdr_ok;
  logic              last_a, last_b, last_r, snd_ack, overrun;

  function automatic logic dim_ok(input dim_t d);
    return (d != 8'd0) && (d <= 8'(MAX_DIM));
  endfunction

  assign loading  = (state == ST_LOAD_A) || (state == ST_LOAD_B);
  assign hdr_last = (state == ST_HDR) && rx_valid && (hdr_cnt == 2'd3);
  // rx_data is the b_w byte on the cycle the header is validated
  assign hdr_ok   = dim_ok(mm_a_h) && dim_ok(mm_a_w) && dim_ok(b_h) &&
                    dim_ok(rx_data) && (mm_a_w == b_h);
  assign last_a   = (16'(word_idx) == elem_count(mm_a_h, mm_a_w) - 16'd1);
  assign last_b   = (16'(word_idx) == elem_count(b_h, mm_b_w) - 16'd1);
  assign last_r   = (16'(res_idx) == elem_count(mm_a_h, mm_b_w) - 16'd1);
  assign snd_ack  = tx_wait && tx_done;
  assign overrun  = rx_valid && ((state == ST_START) || (state == ST_WAIT) ||
                                 (state == ST_RD) || (state == ST_SEND) ||
                                 (state == ST_ACK));

  byte_packer u_packer (
    .clk     (clk),
    .rst     (rst),
    .clr     (!loading),
    .in_vld  (rx_valid),
    .in_byte (rx_data),
    .word    (pk_word),
    .done    (pk_done)
  );

  assign buf_we    = pk_done && loading;
  assign buf_sel   = (state == ST_LOAD_B);
  assign buf_addr  = word_idx;
  assign buf_wdata = pk_word;
  assign mm_start  = (state == ST_START);
  assign res_rd_en = (state == ST_RD);
  assign res_addr  = res_idx;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (rx_valid && (rx_data == MATRIX_MULT)) state_nxt = ST_HDR;
      ST_HDR: begin
        if (hdr_last) begin
`ifdef FUMPY_CMD_ACK_EN
          state_nxt = hdr_ok ? ST_ACK : ST_IDLE;
`else
          state_nxt = hdr_ok ? ST_LOAD_A : ST_IDLE;
`endif
        end
      end
`ifdef FUMPY_CMD_ACK_EN
      ST_ACK:    if (snd_ack) state_nxt = ST_LOAD_A;
`endif
      ST_LOAD_A: if (pk_done && last_a) state_nxt = ST_LOAD_B;
      ST_LOAD_B: if (pk_done && last_b) state_nxt = ST_START;
      ST_START:  state_nxt = ST_WAIT;
      ST_WAIT:   if (mm_done) state_nxt = ST_RD;
      ST_RD:     state_nxt = ST_SEND;
      ST_SEND:   if (snd_ack && (byte_cnt == 2'd3)) state_nxt = last_r ? ST_IDLE : ST_RD;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdr_cnt  <= 2'd0;
      mm_a_h   <= 8'd0;
      mm_a_w   <= 8'd0;
      b_h      <= 8'd0;
      mm_b_w   <= 8'd0;
      word_idx <= '0;
      res_idx  <= '0;
      res_word <= 32'd0;
      byte_cnt <= 2'd0;
      snd_load <= 1'b0;
      tx_wait  <= 1'b0;
      tx_send  <= 1'b0;
      tx_data  <= 8'd0;
      err      <= 1'b0;
    end else begin
      tx_send <= 1'b0;
      if (overrun) err <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (rx_valid && (rx_data == MATRIX_MULT)) begin
            err     <= 1'b0;
            hdr_cnt <= 2'd0;
          end
        end
        ST_HDR: begin
          if (rx_valid) begin
            hdr_cnt <= hdr_cnt + 2'd1;
            case (hdr_cnt)
              2'd0:    mm_a_h <= rx_data;
              2'd1:    mm_a_w <= rx_data;
              2'd2:    b_h    <= rx_data;
              default: mm_b_w <= rx_data;
            endcase
          end
          if (hdr_last) begin
            word_idx <= '0;
            if (!hdr_ok) begin
              err <= 1'b1;
            end else begin
`ifdef FUMPY_CMD_ACK_EN
              tx_send <= 1'b1;
              tx_data <= ACK;
              tx_wait <= 1'b1;
`endif
            end
          end
        end
        ST_ACK: begin
          if (snd_ack) tx_wait <= 1'b0;
        end
        ST_LOAD_A: begin
          if (pk_done) word_idx <= last_a ? '0 : word_idx + ADDR_W'(1);
        end
        ST_LOAD_B: begin
          if (pk_done) word_idx <= last_b ? '0 : word_idx + ADDR_W'(1);
          res_idx <= '0;
        end
        ST_RD: begin
          snd_load <= 1'b1;
          byte_cnt <= 2'd0;
        end
        ST_SEND: begin
          // res_rdata is valid on the first SEND cycle, one after the read strobe
          if (snd_load) begin
            snd_load <= 1'b0;
            res_word <= {res_rdata[23:0], 8'd0};
            tx_data  <= res_rdata[31:24];
            tx_send  <= 1'b1;
            tx_wait  <= 1'b1;
          end else if (snd_ack) begin
            tx_wait <= 1'b0;
            if (byte_cnt != 2'd3) begin
              byte_cnt <= byte_cnt + 2'd1;
              res_word <= {res_word[23:0], 8'd0};
              tx_data  <= res_word[31:24];
              tx_send  <= 1'b1;
              tx_wait  <= 1'b1;
            end else if (!last_r) begin
              res_idx <= res_idx + ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cmd_sequencer.md
# cmd_sequencer

Command sequencer between the host UART link and the matrix-multiply datapath in `fumpy_top`. It parses the byte stream from the UART receiver (opcode, four dimension bytes, then A and B operands as 32-bit IEEE-754 words sent MSB first) and writes the operands into the A/B buffers. It then starts the multiply engine and streams the result matrix back through the UART transmitter, one byte per tx handshake. It owns all protocol state; the UART and the multiply engine stay protocol-agnostic.

## Interface

Parameters:
- MAX_DIM, 4, maximum accepted value of any matrix dimension
- ADDR_W, $clog2(MAX_DIM*MAX_DIM), buffer address width

Ports:
- clk, input, 1, system clock
- rst, input, 1, reset: asynchronous, active-high
- rx_valid, input, 1, one-cycle pulse per received byte (already edge-detected)
- rx_data, input, 8, received byte, valid with rx_valid
- tx_send, output, 1, one-cycle pulse requesting transmission of tx_data
- tx_data, output, 8, byte to transmit, held stable until tx_done
- tx_done, input, 1, one-cycle pulse when the UART finishes a byte
- buf_we, output, 1, operand buffer write strobe
- buf_sel, output, 1, 0 = A buffer, 1 = B buffer
- buf_addr, output, ADDR_W, row-major element index
- buf_wdata, output, 32, assembled operand word
- mm_start, output, 1, one-cycle pulse that starts the multiply
- mm_a_h / mm_a_w / mm_b_w, output, 8 each, registered dimensions, stable from mm_start until IDLE
- mm_done, input, 1, one-cycle pulse when the result buffer is complete
- res_rd_en, output, 1, result buffer read strobe
- res_addr, output, ADDR_W, result element index
- res_rdata, input, 32, result word, valid 1 cycle after res_rd_en
- busy, output, 1, high in every state except IDLE
- err, output, 1, sticky protocol error

## Operation

- State sequence: IDLE → HDR → [ACK] → LOAD_A → LOAD_B → START → WAIT → RD → SEND → RD … → IDLE.
- **IDLE:** an rx byte equal to MATRIX_MULT clears err and moves to HDR. Any other byte is ignored.
- **HDR:** 4 bytes are captured in order: a_h, a_w, b_h, b_w.
  - On the 4th byte, the header is validated: every dimension must be in 1..MAX_DIM, and a_w must equal b_h.
  - On failure: err is set, the block returns to IDLE, and no buffer write occurs.
- **LOAD_A:** receives a_h*a_w words; LOAD_B receives b_h*b_w words.
  - Bytes are shifted into a 32-bit register MSB first, counted by a 2-bit byte counter.
  - After the 4th byte: buf_we pulses, buf_addr equals the word index (restarting at 0 for each buffer), and the word index increments.
- **START:** mm_start pulses for one cycle, then the block enters WAIT.
- **WAIT:** holds until mm_done.
- **RD:** res_rd_en pulses with res_addr = result index; the next cycle latches res_rdata.
- **SEND:** sends 4 bytes, MSB first.
  - Each byte is one tx_send pulse, followed by waiting for tx_done.
  - The next tx_send is issued the cycle after tx_done.
  - After a_h*b_w words have been sent, the block returns to IDLE.
- Element counts are computed as 16-bit products of the 8-bit dimensions.
- **Overrun:** an rx_valid in START, WAIT, RD, SEND or ACK sets err. The byte is dropped and the sequence continues.
- mm_done outside WAIT and tx_done outside a pending send are ignored.

## Timing

- All outputs are 0 under reset, and all state and counters return to IDLE/0 asynchronously.
- A reset asserted mid-transaction abandons the transaction. No partial outputs are held.
- rx byte to state update: 1 cycle. buf_we follows the 4th operand byte's rx_valid by 1 cycle.
- Validation failure reaches IDLE 1 cycle after the 4th header byte.
- mm_start occurs 1 cycle after the last buf_we.
- mm_done to res_rd_en: 1 cycle. res_rd_en to first tx_send: 2 cycles.
- tx_data changes only on the cycle tx_send is asserted.

## Configuration

- Controlled by the macro FUMPY_CMD_ACK_EN.
- **Defined:** after a valid header, the ACK state sends the byte ACK (package constant 8'hA5) via the tx handshake, and enters LOAD_A on its tx_done. Operand bytes that arrive before that tx_done are overruns.
- **Undefined:** the ACK state is not compiled, and HDR goes directly to LOAD_A.

## Structure

- The shared package holds the opcode constants (MATRIX_MULT, ACK), the state enum type `seq_state_t`, and the dimension type `dim_t` (8-bit).
- One sub-module is natural: `byte_packer`, a 4-byte-to-32-bit MSB-first shift register with a done strobe.
- Result serialisation stays inline in the FSM.

## Test plan

- **Operand load:** send MATRIX_MULT, 4,4,4,4, then 1.0..16.0 twice. Expect 16 A writes (addr0 = 0x3F800000 … addr15 = 0x41800000), then 16 B writes, then a single mm_start with dims 4/4/4.
- **Result stream:** stub mm_done 50 cycles after mm_start, with res_rdata[0] = 0x42B40000 (90.0). Expect tx bytes 42, B4, 00, 00 first, 64 tx_send pulses total, then busy = 0.
- **Dimension mismatch:** header 2,3,2,2. Expect err = 1, no buf_we, IDLE. The next MATRIX_MULT clears err.
- **Out-of-range dimension:** header 0,4,4,4 or 5,4,4,4 with MAX_DIM = 4. Expect err = 1.
- **Reset mid-load:** assert rst during LOAD_B. All outputs go to 0. A following full transaction writes starting from addr 0 and completes correctly.
- **ACK option:** with FUMPY_CMD_ACK_EN defined, the header is followed by tx_data = 0xA5 before the first buf_we. With it undefined, no transmission occurs before mm_done.
